// File: rtl/switch_route_allocator.sv
// Route reservation table for an N-port switch: one round-robin arbiter per output,
// per-input reserve status, and registered crossbar selects held until the owner relieves.
module switch_route_allocator #(
    parameter int unsigned N             = 4,
    parameter int unsigned REQUEST_WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               routeReserveRequestValid,
    input  logic [N*REQUEST_WIDTH-1:0] routeReserveRequest,
    input  logic [N-1:0]               routeRelieve,
    output logic [N-1:0]               routeReserveStatus,
    output logic [N-1:0]               outputBusy,
    output logic [N*REQUEST_WIDTH-1:0] outputSelect
);

    localparam int unsigned RW = REQUEST_WIDTH;

    logic [N-1:0]    status_q, status_d;
    logic [N-1:0]    busy_q, busy_d;
    logic [N*RW-1:0] owner_q, owner_d;
    logic [N*RW-1:0] rr_q, rr_d;

    logic        found;
    int unsigned win;
    int unsigned idx;

    always_comb begin
        status_d = status_q;
        busy_d   = busy_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        found    = 1'b0;
        win      = 0;
        idx      = 0;

        // Grants only touch free outputs and route-less inputs, so they never
        // collide with a relieve, which only touches busy outputs and holding inputs.
        for (int unsigned j = 0; j < N; j++) begin
            found = 1'b0;
            win   = 0;
            for (int unsigned k = 0; k < N; k++) begin
                idx = (32'(rr_q[j*RW +: RW]) + k) % N;
                if (!found && !busy_q[j] && routeReserveRequestValid[idx] && !status_q[idx]
                    && (routeReserveRequest[idx*RW +: RW] == RW'(j))) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
            if (found) begin
                busy_d[j]            = 1'b1;
                owner_d[j*RW +: RW]  = RW'(win);
                status_d[win]        = 1'b1;
                rr_d[j*RW +: RW]     = RW'((win + 1) % N);
            end
        end

        for (int unsigned i = 0; i < N; i++) begin
            if (routeRelieve[i] && status_q[i]) begin
                status_d[i] = 1'b0;
                for (int unsigned j = 0; j < N; j++) begin
                    if (busy_q[j] && (owner_q[j*RW +: RW] == RW'(i))) begin
                        busy_d[j] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= '0;
            busy_q   <= '0;
            owner_q  <= '0;
            rr_q     <= '0;
        end else begin
            status_q <= status_d;
            busy_q   <= busy_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
        end
    end

    assign routeReserveStatus = status_q;
    assign outputBusy         = busy_q;
    assign outputSelect       = owner_q;

endmodule

// File: tb/tb_switch_route_allocator.sv
// Randomized and directed bench for switch_route_allocator against a behavioural
// model that tracks which output each input holds.
module tb_switch_route_allocator;

    localparam int N  = 4;
    localparam int RW = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    valid;
    logic [N*RW-1:0] req;
    logic [N-1:0]    rel;
    logic [N-1:0]    status;
    logic [N-1:0]    busy;
    logic [N*RW-1:0] sel;

    logic [2:0] v3;
    logic [5:0] r3;
    logic [2:0] rel3;
    logic [2:0] st3;
    logic [2:0] busy3;
    logic [5:0] sel3;

    int checks = 0;
    int errors = 0;

    // Model: output held by each input (-1 none), retained select and rr pointer per output.
    int held_m[N];
    int sel_m[N];
    int rr_m[N];

    switch_route_allocator #(.N(N), .REQUEST_WIDTH(RW)) dut (
        .clk(clk), .rst(rst),
        .routeReserveRequestValid(valid), .routeReserveRequest(req), .routeRelieve(rel),
        .routeReserveStatus(status), .outputBusy(busy), .outputSelect(sel)
    );

    switch_route_allocator #(.N(3), .REQUEST_WIDTH(2)) dut3 (
        .clk(clk), .rst(rst),
        .routeReserveRequestValid(v3), .routeReserveRequest(r3), .routeRelieve(rel3),
        .routeReserveStatus(st3), .outputBusy(busy3), .outputSelect(sel3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        int nheld[N];
        int best, bd, d;
        bit taken;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                held_m[i] = -1;
                sel_m[i]  = 0;
                rr_m[i]   = 0;
            end
            return;
        end
        nheld = held_m;
        for (int j = 0; j < N; j++) begin
            taken = 1'b0;
            for (int i = 0; i < N; i++) if (held_m[i] == j) taken = 1'b1;
            if (!taken) begin
                best = -1;
                bd   = N;
                for (int i = 0; i < N; i++) begin
                    if (valid[i] && held_m[i] < 0 && int'(req[i*RW +: RW]) == j) begin
                        d = (i + N - rr_m[j]) % N;
                        if (d < bd) begin
                            bd   = d;
                            best = i;
                        end
                    end
                end
                if (best >= 0) begin
                    nheld[best] = j;
                    sel_m[j]    = best;
                    rr_m[j]     = (best + 1) % N;
                end
            end
        end
        for (int i = 0; i < N; i++) if (rel[i] && held_m[i] >= 0) nheld[i] = -1;
        held_m = nheld;
    endtask

    task automatic step();
        logic [N-1:0]    es;
        logic [N-1:0]    eb;
        logic [N*RW-1:0] esel;
        @(posedge clk);
        model_edge();
        #1;
        es = '0;
        eb = '0;
        for (int i = 0; i < N; i++) begin
            if (held_m[i] >= 0) begin
                es[i]         = 1'b1;
                eb[held_m[i]] = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) esel[j*RW +: RW] = 2'(sel_m[j]);
        check("model_status", 32'(status), 32'(es));
        check("model_busy", 32'(busy), 32'(eb));
        check("model_select", 32'(sel), 32'(esel));
    endtask

    int exp_order[3] = '{0, 1, 3};
    logic [1:0] got;
    int c;

    initial begin
        for (int i = 0; i < N; i++) begin
            held_m[i] = -1;
            sel_m[i]  = 0;
            rr_m[i]   = 0;
        end
        rst = 1'b1; valid = '1; req = '0; rel = '0;
        v3 = '0; r3 = '0; rel3 = '0;

        // Reset with all inputs requesting
        for (int n = 0; n < 2; n++) begin
            step();
            check("rst_status", 32'(status), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_select", 32'(sel), 0);
        end
        rst = 1'b0; valid = '0;

        // Single grant then relieve
        valid = 4'b0100; req = 8'b00_01_00_00;
        step();
        check("single_status", 32'(status), 32'h4);
        check("single_busy", 32'(busy), 32'h2);
        check("single_sel1", 32'(sel[3:2]), 2);
        valid = '0; rel = 4'b0100;
        step();
        rel = '0;
        check("single_rel_status", 32'(status), 0);
        check("single_rel_busy", 32'(busy), 0);

        // Parallel grants
        valid = 4'hF; req = 8'h1B;
        step();
        check("par_status", 32'(status), 32'hF);
        check("par_busy", 32'(busy), 32'hF);
        check("par_select", 32'(sel), 32'h1B);
        valid = '0; rel = 4'hF;
        step();
        rel = '0;

        // Contention on output 2 from a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        valid = 4'b1011; req = 8'h8A;
        for (int n = 0; n < 4; n++) begin
            c = 0;
            while (!busy[2] && c < 6) begin
                step();
                c++;
            end
            check("cont_busy", 32'(busy[2]), 1);
            got = sel[5:4];
            check("cont_order", 32'(got), (n < 3) ? exp_order[n] : 0);
            if (n == 2) begin
                rel[got] = 1'b1;
                valid = 4'b1001;
            end else if (n == 3) begin
                rel[got] = 1'b1;
                valid = '0;
            end else begin
                rel[got] = 1'b1;
                valid[got] = 1'b0;
            end
            step();
            rel = '0;
        end

        // Same-cycle relieve and request on one output
        valid = 4'b0010; req = '0;
        step();
        valid = '0;
        check("same_own", 32'(status), 32'h2);
        rel = 4'b0010; valid = 4'b1000;
        step();
        rel = '0;
        check("same_bubble_status", 32'(status), 0);
        check("same_bubble_busy", 32'(busy), 0);
        step();
        check("same_grant_status", 32'(status), 32'h8);
        check("same_grant_sel0", 32'(sel[1:0]), 3);
        valid = '0; rel = 4'b1000;
        step();
        rel = '0;

        // Randomized traffic with occasional resets and spurious relieves
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < N; i++) begin
                if (held_m[i] < 0) begin
                    rel[i] = ($urandom_range(0, 15) == 0);
                    if (!valid[i] || $urandom_range(0, 7) == 0) begin
                        valid[i] = ($urandom_range(0, 2) != 0);
                        req[i*RW +: RW] = 2'($urandom_range(0, N - 1));
                    end
                end else begin
                    rel[i]   = ($urandom_range(0, 3) == 0);
                    valid[i] = ($urandom_range(0, 1) == 1);
                    req[i*RW +: RW] = 2'($urandom_range(0, N - 1));
                end
            end
            step();
        end
        rst = 1'b0; rel = '0;

        // Out-of-range index on a 3-port instance, then reset mid-hold
        valid = 4'hF; req = 8'h1B;
        v3 = 3'b011; r3 = 6'b00_00_11;
        for (int n = 0; n < 6; n++) begin
            step();
            check("n3_status", 32'(st3), 32'h2);
            check("n3_busy", 32'(busy3), 32'h1);
            check("n3_sel0", 32'(sel3[1:0]), 1);
        end
        rst = 1'b1;
        step();
        check("midrst_status", 32'(status), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_n3_status", 32'(st3), 0);
        rst = 1'b0; valid = '0; v3 = '0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
